// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolls buffered pipe columns right-to-left across the playfield with gap columns
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   enable      - game running; scrolling advances only while high
//   col_valid   - column offered on col_data
//   col_data    - incoming pipe column, bit r = pipe block at row r
//   col_ready   - one-column buffer is empty
//   grid        - playfield image, column c at [c*ROWS +: ROWS]
//   pass_pulse  - one-cycle pulse after a pipe column leaves BIRD_COL
//   underrun    - sticky; a pipe slot found the buffer empty
module pipe_scroller #(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int SCROLL_DIV = 4,
    parameter int GAP_COLS   = 3,
    parameter int BIRD_COL   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 col_valid,
    input  logic [ROWS-1:0]      col_data,
    output logic                 col_ready,
    output logic [COLS*ROWS-1:0] grid,
    output logic                 pass_pulse,
    output logic                 underrun
);
    localparam int TW = $clog2(SCROLL_DIV);
    localparam int SW = $clog2(GAP_COLS + 2);
    localparam logic [TW-1:0] TICK_MAX = TW'(SCROLL_DIV - 1);
    localparam logic [SW-1:0] GAP = SW'(GAP_COLS);
    typedef enum logic {EMPTY, FULL} buf_state_t;
    buf_state_t      state;
    logic [ROWS-1:0] buf_data;
    logic [TW-1:0]   tick_cnt;
    logic [SW-1:0]   spacer_cnt;
    logic [COLS-1:0] marker;
    logic            step, pipe_slot, consume;
    logic [ROWS-1:0] entry;
    assign col_ready = state == EMPTY;
    assign step      = enable && tick_cnt == TICK_MAX;
    assign pipe_slot = step && spacer_cnt == GAP;
    assign consume   = pipe_slot && state == FULL;
    assign entry     = consume ? buf_data : '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            buf_data   <= '0;
            tick_cnt   <= '0;
            spacer_cnt <= GAP;
            marker     <= '0;
            grid       <= '0;
            pass_pulse <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            pass_pulse <= step && marker[BIRD_COL];
            if (enable)
                tick_cnt <= step ? '0 : tick_cnt + TW'(1);
            if (step) begin
                grid       <= {entry, grid[COLS*ROWS-1:ROWS]};
                marker     <= {consume, marker[COLS-1:1]};
                // an empty pipe slot leaves spacer_cnt at GAP so the pipe is retried next step
                spacer_cnt <= spacer_cnt < GAP ? spacer_cnt + SW'(1) : consume ? '0 : spacer_cnt;
                if (pipe_slot && !consume)
                    underrun <= 1'b1;
            end
            if (state == EMPTY && col_valid) begin
                buf_data <= col_data;
                state    <= FULL;
            end else if (consume) begin
                state <= EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller: self-checking bench for pipe_scroller
module tb_pipe_scroller;
    logic         clk = 1'b0;
    logic         reset, enable, col_valid;
    logic [15:0]  col_data;
    logic         col_ready;
    logic [255:0] grid;
    logic         pass_pulse, underrun;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [15:0] data;
        logic        push;
        logic        pipe;
        logic        ready;
    } vec_t;
    vec_t vecs[10];
    logic [15:0]  sbq[$];
    logic [255:0] exp_grid;

    always #5 clk = ~clk;

    pipe_scroller dut (
        .clk(clk), .reset(reset), .enable(enable), .col_valid(col_valid),
        .col_data(col_data), .col_ready(col_ready), .grid(grid),
        .pass_pulse(pass_pulse), .underrun(underrun)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1; enable = 1'b0; col_valid = 1'b0; col_data = '0;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] entry;
        int pulses;
        reset = 1'b1; enable = 1'b0; col_valid = 1'b0; col_data = '0;
        do_reset();
        chk("reset_grid", grid, '0);
        chk("reset_ready", col_ready, 1);
        chk("reset_pass", pass_pulse, 0);
        chk("reset_underrun", underrun, 0);

        // first column: accept at edge 1, enters at the 4th enabled edge
        enable = 1'b1; col_valid = 1'b1; col_data = 16'hF81F;
        cyc(1); chk("ready_after_accept", col_ready, 0);
        cyc(2); chk("grid_before_step", grid, '0);
        cyc(1); chk("first_step_grid", grid, {16'hF81F, 240'b0});
        chk("ready_after_consume", col_ready, 1);
        col_valid = 1'b0;
        cyc(1); chk("ready_stays", col_ready, 1);

        // table-driven stream with col_valid held high; accepted columns go to the scoreboard
        vecs[0] = '{16'hE007, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{16'h1234, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'hAAAA, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'hBBBB, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'hCCCC, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{16'hE007, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'h0101, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h0202, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'h0303, 1'b0, 1'b1, 1'b1};
        vecs[9] = '{16'h5555, 1'b1, 1'b0, 1'b0};
        do_reset();
        exp_grid = '0;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            col_valid = 1'b1;
            col_data = vecs[i].data;
            if (vecs[i].push) sbq.push_back(vecs[i].data);
            cyc(4);
            entry = '0;
            if (vecs[i].pipe) begin
                if (sbq.size() == 0) chk($sformatf("tbl%0d_sb_empty", i), 0, 1);
                else entry = sbq.pop_front();
            end
            exp_grid = {entry, exp_grid[255:16]};
            chk($sformatf("tbl%0d_col15", i), grid[255:240], entry);
            chk($sformatf("tbl%0d_grid", i), grid, exp_grid);
            chk($sformatf("tbl%0d_ready", i), col_ready, vecs[i].ready);
            chk($sformatf("tbl%0d_underrun", i), underrun, 0);
            chk($sformatf("tbl%0d_pass", i), pass_pulse, 0);
        end
        col_valid = 1'b0;

        // underrun: single column, then the next pipe slot finds the buffer empty
        do_reset();
        enable = 1'b1; col_valid = 1'b1; col_data = 16'h1111;
        cyc(1); col_valid = 1'b0;
        cyc(3); chk("ur_step1_col15", grid[255:240], 16'h1111);
        cyc(16);
        chk("ur_set", underrun, 1);
        chk("ur_step5_grid", grid, 256'h1111 << (11 * 16));
        col_valid = 1'b1; col_data = 16'h0FF0;
        cyc(1); col_valid = 1'b0;
        cyc(3);
        chk("ur_retry_grid", grid, {16'h0FF0, 64'b0, 16'h1111, 160'b0});
        chk("ur_sticky", underrun, 1);

        // pass pulse: the step-1 pipe passes the bird on step 14
        pulses = 0;
        for (int s = 7; s <= 16; s++) begin
            for (int k = 0; k < 4; k++) begin
                cyc(1);
                if (pass_pulse) pulses++;
                if (k == 3 && s == 13) chk("pass_col3_step13", grid[63:48], 16'h1111);
                if (k == 3 && s == 14) chk("pass_after_step14", pass_pulse, 1);
            end
        end
        chk("pass_count", pulses, 1);
        chk("ur_still_set", underrun, 1);

        // asynchronous reset with buffer full and grid non-zero
        col_valid = 1'b1; col_data = 16'hABCD;
        cyc(1); col_valid = 1'b0;
        chk("ar_pre_full", col_ready, 0);
        chk("ar_pre_grid_nz", grid != '0, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_grid", grid, '0);
        chk("ar_ready", col_ready, 1);
        chk("ar_underrun", underrun, 0);
        chk("ar_pass", pass_pulse, 0);
        cyc(1); reset = 1'b0;

        // pause mid-scroll: state frozen, prefetch still accepted
        do_reset();
        enable = 1'b1; col_valid = 1'b1; col_data = 16'h3C3C;
        cyc(1); col_valid = 1'b0;
        cyc(5);
        chk("pause_pre_grid", grid, {16'h3C3C, 240'b0});
        enable = 1'b0; col_valid = 1'b1; col_data = 16'h7E7E;
        cyc(1); col_valid = 1'b0;
        chk("pause_accept", col_ready, 0);
        cyc(19);
        chk("pause_grid", grid, {16'h3C3C, 240'b0});
        chk("pause_pass", pass_pulse, 0);
        enable = 1'b1;
        cyc(1); chk("resume_no_step", grid, {16'h3C3C, 240'b0});
        cyc(1); chk("resume_step2", grid, {16'h0, 16'h3C3C, 224'b0});
        cyc(12);
        chk("resume_step5", grid, {16'h7E7E, 48'b0, 16'h3C3C, 176'b0});
        chk("resume_underrun", underrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
